// File: rtl/mems_mics_frame_writer.sv
// mems_mics_frame_writer
//   Collects one PCM sample per channel from the MEMS mic decimators into a
//   256-bit frame (NUM_CH lanes of SAMPLE_W bits). Each completed frame is
//   written into the dual-port RAM through its s2 Avalon port. The RAM is used
//   as a ring buffer, and this block tracks write/read pointers and fill level
//   for the HPS reader on s1.
//   Optional feature macro: MEMS_FRAME_IRQ_EN. When it is defined, a registered
//   level IRQ is built for (fill_level >= IRQ_THRESH) | overflow. When it is
//   undefined, irq is tied low.
module mems_mics_frame_writer #(
  parameter int NUM_CH   = 16,
  parameter int SAMPLE_W = 16,
  parameter int ADDR_W   = 7
`ifdef MEMS_FRAME_IRQ_EN
  ,
  parameter int IRQ_THRESH = 64
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         sample_valid,
  input  logic [$clog2(NUM_CH)-1:0]    sample_ch,
  input  logic [SAMPLE_W-1:0]          sample_data,
  output logic [ADDR_W-1:0]            ram_address,
  output logic [NUM_CH*SAMPLE_W-1:0]   ram_writedata,
  output logic [NUM_CH*SAMPLE_W/8-1:0] ram_byteenable,
  output logic                         ram_chipselect,
  output logic                         ram_write,
  input  logic                         rd_release,
  input  logic [ADDR_W:0]              rd_release_cnt,
  output logic [ADDR_W-1:0]            wr_ptr,
  output logic [ADDR_W-1:0]            rd_ptr,
  output logic [ADDR_W:0]              fill_level,
  output logic                         overflow,
  output logic                         release_err,
  output logic [15:0]                  dropped_cnt,
  input  logic                         clear_err,
  output logic                         irq
);

  localparam int FRAME_W = NUM_CH * SAMPLE_W;
  localparam int FILL_W  = ADDR_W + 1;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic IDLE    = 1'b0;
  localparam logic COLLECT = 1'b1;

  logic               state_q, state_d;
  logic [FRAME_W-1:0] asm_q, asm_d;       // frame under assembly
  logic [NUM_CH-1:0]  mask_q, mask_d;     // lanes filled so far
  logic [FRAME_W-1:0] hold_q, hold_d;     // completed frame awaiting its RAM write
  logic               pend_q, pend_d;     // RAM write strobe for this cycle
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               overflow_q, overflow_d;
  logic               rel_err_q, rel_err_d;
  logic [15:0]        dropped_q, dropped_d;

  logic               frame_done;
  logic               buf_full;
  logic               drop_evt;
  logic               rel_err_evt;
  logic [FILL_W-1:0]  rel_amt;
  logic [NUM_CH-1:0]  ch_onehot;

  assign ch_onehot = NUM_CH'(1) << sample_ch;
  assign buf_full  = (fill_q == FILL_W'(DEPTH));

  // Frame assembly FSM: fill lanes, hand a complete frame to the holding register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    asm_d      = asm_q;
    mask_d     = mask_q;
    hold_d     = hold_q;
    pend_d     = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = COLLECT;
      end
      COLLECT: begin
        if (!enable) begin
          // Abandon the partial frame; a write already pending still finishes.
          state_d = IDLE;
          mask_d  = '0;
          asm_d   = '0;
        end else if (sample_valid) begin
          asm_d[sample_ch*SAMPLE_W +: SAMPLE_W] = sample_data;
          mask_d = mask_q | ch_onehot;
          if (&mask_d) begin
            frame_done = 1'b1;
            mask_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // The full check looks at the fill level as it stood before any same-cycle release.
    if (frame_done && !buf_full) begin
      hold_d = asm_d;
      pend_d = 1'b1;
    end
  end

  assign drop_evt    = frame_done && buf_full;
  assign rel_err_evt = rd_release && (rd_release_cnt > fill_q);

  // Ring pointers, fill level and sticky error bookkeeping.
  always_comb begin
    rel_amt = '0;
    if (rd_release) rel_amt = rel_err_evt ? fill_q : rd_release_cnt;

    wr_ptr_d = wr_ptr_q + ADDR_W'(pend_q);
    rd_ptr_d = rd_ptr_q + rel_amt[ADDR_W-1:0];
    fill_d   = fill_q + FILL_W'(pend_q) - rel_amt;

    // A new error event in the same cycle wins over clear_err.
    overflow_d = drop_evt    ? 1'b1 : (clear_err ? 1'b0 : overflow_q);
    rel_err_d  = rel_err_evt ? 1'b1 : (clear_err ? 1'b0 : rel_err_q);

    dropped_d = dropped_q;
    if (drop_evt) begin
      if (clear_err)              dropped_d = 16'd1;
      else if (dropped_q != '1)   dropped_d = dropped_q + 16'd1;
    end else if (clear_err) begin
      dropped_d = '0;
    end
  end

  // State registers; async reset also drops an in-flight RAM write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      asm_q      <= '0;
      mask_q     <= '0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      rel_err_q  <= 1'b0;
      dropped_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      asm_q      <= asm_d;
      mask_q     <= mask_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      rel_err_q  <= rel_err_d;
      dropped_q  <= dropped_d;
    end
  end

`ifdef MEMS_FRAME_IRQ_EN
  logic irq_q;

  // Level IRQ registered one cycle behind fill/overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= (fill_q >= FILL_W'(IRQ_THRESH)) | overflow_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign ram_address    = wr_ptr_q;
  assign ram_writedata  = hold_q;
  assign ram_byteenable = '1;
  assign ram_chipselect = pend_q;
  assign ram_write      = pend_q;
  assign wr_ptr         = wr_ptr_q;
  assign rd_ptr         = rd_ptr_q;
  assign fill_level     = fill_q;
  assign overflow       = overflow_q;
  assign release_err    = rel_err_q;
  assign dropped_cnt    = dropped_q;

endmodule

// File: tb/tb_mems_mics_frame_writer.sv
// Testbench for mems_mics_frame_writer.
// A scoreboard queue holds the expected RAM writes (address and data) for each
// frame the bench sends. A negedge monitor pops one entry for every observed
// write and compares it. The irq checks follow MEMS_FRAME_IRQ_EN.
module tb_mems_mics_frame_writer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         sample_valid;
  logic [3:0]   sample_ch;
  logic [15:0]  sample_data;
  logic [6:0]   ram_address;
  logic [255:0] ram_writedata;
  logic [31:0]  ram_byteenable;
  logic         ram_chipselect;
  logic         ram_write;
  logic         rd_release;
  logic [7:0]   rd_release_cnt;
  logic [6:0]   wr_ptr;
  logic [6:0]   rd_ptr;
  logic [7:0]   fill_level;
  logic         overflow;
  logic         release_err;
  logic [15:0]  dropped_cnt;
  logic         clear_err;
  logic         irq;

  typedef struct packed {
    logic [6:0]   addr;
    logic [255:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n_wr     = 0;

`ifdef MEMS_FRAME_IRQ_EN
  localparam logic IRQ_ON_OVF = 1'b1;
`else
  localparam logic IRQ_ON_OVF = 1'b0;
`endif

  mems_mics_frame_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .sample_valid   (sample_valid),
    .sample_ch      (sample_ch),
    .sample_data    (sample_data),
    .ram_address    (ram_address),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .rd_release     (rd_release),
    .rd_release_cnt (rd_release_cnt),
    .wr_ptr         (wr_ptr),
    .rd_ptr         (rd_ptr),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .release_err    (release_err),
    .dropped_cnt    (dropped_cnt),
    .clear_err      (clear_err),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every RAM write must match the oldest expected frame.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && ram_write === 1'b1) begin
      n_wr++;
      check("wr_chipselect", 256'(ram_chipselect), 256'd1);
      check("wr_byteenable", 256'(ram_byteenable), 256'hFFFF_FFFF);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 256'(ram_address), 256'h1FF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 256'(ram_address), 256'(e.addr));
        check("wr_data", ram_writedata, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    enable         = 1'b0;
    sample_valid   = 1'b0;
    sample_ch      = '0;
    sample_data    = '0;
    rd_release     = 1'b0;
    rd_release_cnt = '0;
    clear_err      = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    n_wr = 0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic send(input logic [3:0] ch, input logic [15:0] d);
    sample_valid = 1'b1;
    sample_ch    = ch;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  // Send a full frame whose lane c carries base+c, optionally in reverse channel order.
  task automatic send_frame(input logic [6:0] addr, input logic [15:0] base,
                            input bit push, input bit rev);
    wr_t e;
    e.addr = addr;
    for (int c = 0; c < 16; c++) e.data[c*16 +: 16] = base + 16'(c);
    if (push) exp_q.push_back(e);
    for (int i = 0; i < 16; i++) begin
      int c;
      c = rev ? 15 - i : i;
      send(4'(c), base + 16'(c));
    end
  endtask

  task automatic release_frames(input logic [7:0] cnt);
    rd_release     = 1'b1;
    rd_release_cnt = cnt;
    tick();
    rd_release     = 1'b0;
    rd_release_cnt = '0;
  endtask

  initial begin
    wr_t e;

    // Reset state
    do_reset();
    check("rst_write",      256'(ram_write),      256'd0);
    check("rst_cs",         256'(ram_chipselect), 256'd0);
    check("rst_byteenable", 256'(ram_byteenable), 256'hFFFF_FFFF);
    check("rst_wr_ptr",     256'(wr_ptr),         256'd0);
    check("rst_rd_ptr",     256'(rd_ptr),         256'd0);
    check("rst_fill",       256'(fill_level),     256'd0);
    check("rst_flags",      256'({overflow, release_err, irq}), 256'd0);
    check("rst_dropped",    256'(dropped_cnt),    256'd0);

    // 1: single frame ch0..15, data 0x1000+ch
    start();
    send_frame(7'd0, 16'h1000, 1'b1, 1'b0);
    tick();
    tick();
    check("t1_wr_ptr", 256'(wr_ptr),     256'd1);
    check("t1_fill",   256'(fill_level), 256'd1);
    check("t1_nwr",    256'(n_wr),       256'd1);
    check("t1_queue",  256'(exp_q.size()), 256'd0);

    // 2: reverse-order frame, then a frame with ch3 sent twice
    do_reset();
    start();
    send_frame(7'd0, 16'h2000, 1'b1, 1'b1);
    e.addr = 7'd1;
    for (int c = 0; c < 16; c++) e.data[c*16 +: 16] = 16'h3000 + 16'(c);
    e.data[3*16 +: 16] = 16'h5555;
    exp_q.push_back(e);
    send(4'd3, 16'hAAAA);
    for (int c = 0; c < 16; c++) send(4'(c), (c == 3) ? 16'h5555 : 16'h3000 + 16'(c));
    tick();
    tick();
    check("t2_nwr",   256'(n_wr),       256'd2);
    check("t2_fill",  256'(fill_level), 256'd2);
    check("t2_queue", 256'(exp_q.size()), 256'd0);

    // 3: fill the ring, overflow on the 129th frame, then clear_err
    do_reset();
    start();
    for (int f = 0; f < 128; f++) send_frame(7'(f), 16'(f * 16), 1'b1, 1'b0);
    tick();
    tick();
    check("t3_fill_full",  256'(fill_level), 256'd128);
    check("t3_wr_wrap",    256'(wr_ptr),     256'd0);
    check("t3_no_ovf_yet", 256'(overflow),   256'd0);
    check("t3_nwr128",     256'(n_wr),       256'd128);
    send_frame(7'd0, 16'hF000, 1'b0, 1'b0);
    tick();
    tick();
    check("t3_nwr_drop",  256'(n_wr),        256'd128);
    check("t3_overflow",  256'(overflow),    256'd1);
    check("t3_dropped",   256'(dropped_cnt), 256'd1);
    check("t3_wr_hold",   256'(wr_ptr),      256'd0);
    check("t3_irq_ovf",   256'(irq),         256'(IRQ_ON_OVF));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t3_clr_ovf",     256'(overflow),    256'd0);
    check("t3_clr_dropped", 256'(dropped_cnt), 256'd0);
    check("t3_fill_kept",   256'(fill_level),  256'd128);

    // 4: release coinciding with a write, then an over-release
    do_reset();
    start();
    for (int f = 0; f < 10; f++) send_frame(7'(f), 16'(16'h4000 + f * 16), 1'b1, 1'b0);
    tick();
    check("t4_fill10", 256'(fill_level), 256'd10);
    send_frame(7'd10, 16'h4A00, 1'b1, 1'b0);
    check("t4_write_now", 256'(ram_write), 256'd1);
    release_frames(8'd4);
    check("t4_fill7",   256'(fill_level),  256'd7);
    check("t4_rd_ptr4", 256'(rd_ptr),      256'd4);
    check("t4_wr_ptr",  256'(wr_ptr),      256'd11);
    check("t4_no_err",  256'(release_err), 256'd0);
    release_frames(8'd20);
    check("t4_fill0",    256'(fill_level),  256'd0);
    check("t4_rd_ptr11", 256'(rd_ptr),      256'd11);
    check("t4_rel_err",  256'(release_err), 256'd1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_clr_rel_err", 256'(release_err), 256'd0);
    check("t4_queue",       256'(exp_q.size()), 256'd0);

    // 5: partial frame discarded when enable drops
    do_reset();
    start();
    for (int c = 0; c < 7; c++) send(4'(c), 16'hDE00 + 16'(c));
    enable = 1'b0;
    tick();
    tick();
    start();
    send_frame(7'd0, 16'h5000, 1'b1, 1'b1);
    tick();
    tick();
    check("t5_nwr",   256'(n_wr),       256'd1);
    check("t5_fill",  256'(fill_level), 256'd1);
    check("t5_queue", 256'(exp_q.size()), 256'd0);

`ifdef MEMS_FRAME_IRQ_EN
    // 6: irq threshold at 64 with one-cycle registration
    do_reset();
    start();
    for (int f = 0; f < 63; f++) send_frame(7'(f), 16'(f * 16), 1'b1, 1'b0);
    tick();
    tick();
    check("t6_fill63", 256'(fill_level), 256'd63);
    check("t6_irq63",  256'(irq),        256'd0);
    send_frame(7'd63, 16'h6300, 1'b1, 1'b0);
    tick();
    check("t6_fill64",     256'(fill_level), 256'd64);
    check("t6_irq_lag",    256'(irq),        256'd0);
    tick();
    check("t6_irq_set",    256'(irq),        256'd1);
    release_frames(8'd1);
    check("t6_fill_back",  256'(fill_level), 256'd63);
    check("t6_irq_hold",   256'(irq),        256'd1);
    tick();
    check("t6_irq_clear",  256'(irq),        256'd0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
